// File: rtl/std_sync_write_arbiter.sv
// Two-writer round-robin arbiter feeding a single M-structure sync register.
// The granted writer's data is captured on the grant edge, so a writer only
// has to hold write_en_k (not in_k) until its write_done_k pulse.
module std_sync_write_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_0,
    input  logic             write_en_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic             write_en_1,
    input  logic             reg_done,
    output logic [WIDTH-1:0] reg_in,
    output logic             reg_write_en,
    output logic             write_done_0,
    output logic             write_done_1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_0 = 2'd1,
        BUSY_1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_grant_q, last_grant_d;
    logic             req_any;
    logic             req_sel;

    // Request decode: on a tie the writer that was not served last wins.
    always_comb begin
        req_any = write_en_0 | write_en_1;
        req_sel = 1'b0;
        if (write_en_0 && write_en_1) begin
            req_sel = ~last_grant_q;
        end else if (write_en_1) begin
            req_sel = 1'b1;
        end
    end

    // State, data latch and round-robin pointer; pointer resets to 1 so writer 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            data_q       <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state plus downstream handshake; write_en drops on the done cycle to avoid a second write.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        reg_write_en = 1'b0;
        write_done_0 = 1'b0;
        write_done_1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = req_sel ? BUSY_1 : BUSY_0;
                    data_d  = req_sel ? in_1 : in_0;
                end
            end
            BUSY_0: begin
                reg_write_en = ~reg_done;
                if (reg_done) begin
                    write_done_0 = 1'b1;
                    last_grant_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            BUSY_1: begin
                reg_write_en = ~reg_done;
                if (reg_done) begin
                    write_done_1 = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Downstream data always comes from the latch, so it holds its value while idle.
    assign reg_in = data_q;

    // Completion pulses are mutually exclusive.
    assert property (@(posedge clk) disable iff (reset) !(write_done_0 && write_done_1));

endmodule

// File: tb/tb_std_sync_write_arbiter.sv
// Bench for std_sync_write_arbiter: a behavioural sync register sits downstream,
// writers and a reader are driven from tasks, expectations come from the
// arbitration rules (alternation on ties, one done per request, data captured at grant).
module tb_std_sync_write_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_0;
    logic             write_en_0;
    logic [WIDTH-1:0] in_1;
    logic             write_en_1;
    logic             reg_done;
    logic [WIDTH-1:0] reg_in;
    logic             reg_write_en;
    logic             write_done_0;
    logic             write_done_1;

    int n_checks = 0;
    int n_fail   = 0;

    std_sync_write_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_0         (in_0),
        .write_en_0   (write_en_0),
        .in_1         (in_1),
        .write_en_1   (write_en_1),
        .reg_done     (reg_done),
        .reg_in       (reg_in),
        .reg_write_en (reg_write_en),
        .write_done_0 (write_done_0),
        .write_done_1 (write_done_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural M-structure register: write when empty, done one cycle later, read empties it.
    logic             sr_full;
    logic             sr_done;
    logic [WIDTH-1:0] sr_data;
    logic             rd_en;
    logic             inj_done;
    logic [WIDTH-1:0] wr_log[$];
    int               done_log[$];
    int               done0_cnt = 0;
    int               done1_cnt = 0;

    assign reg_done = sr_done | inj_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_full <= 1'b0;
            sr_done <= 1'b0;
            sr_data <= '0;
        end else begin
            sr_done <= 1'b0;
            if (reg_write_en && !sr_full) begin
                sr_data <= reg_in;
                sr_full <= 1'b1;
                sr_done <= 1'b1;
                wr_log.push_back(reg_in);
            end else if (rd_en && sr_full) begin
                sr_full <= 1'b0;
            end
        end
    end

    // Done-pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (write_done_0) begin
                done0_cnt++;
                done_log.push_back(0);
            end
            if (write_done_1) begin
                done1_cnt++;
                done_log.push_back(1);
            end
        end
    end

    // Advance to just after the next falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_en_0 = 1'b0;
        write_en_1 = 1'b0;
        rd_en      = 1'b0;
        inj_done   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        in_0 = $urandom;
        in_1 = $urandom;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b want 0", reg_write_en); end
        n_checks++; if (reg_in !== '0) begin n_fail++; $display("FAIL rst_reg_in: got %0h want 0", reg_in); end
        n_checks++; if (write_done_0 !== 1'b0) begin n_fail++; $display("FAIL rst_done0: got %b want 0", write_done_0); end
        n_checks++; if (write_done_1 !== 1'b0) begin n_fail++; $display("FAIL rst_done1: got %b want 0", write_done_1); end
        step();
        step();
        reset = 1'b0;
        step();
        n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_idle_wen: got %b want 0", reg_write_en); end
    endtask

    task automatic test_single_write();
        int d0, d1;
        d0 = done0_cnt;
        d1 = done1_cnt;
        in_0 = 32'hA5;
        write_en_0 = 1'b1;
        step();
        n_checks++; if (reg_write_en !== 1'b1) begin n_fail++; $display("FAIL single_wen_t1: got %b want 1", reg_write_en); end
        n_checks++; if (reg_in !== 32'hA5) begin n_fail++; $display("FAIL single_data_t1: got %0h want a5", reg_in); end
        n_checks++; if (write_done_0 !== 1'b0) begin n_fail++; $display("FAIL single_done0_t1: got %b want 0", write_done_0); end
        step();
        n_checks++; if (write_done_0 !== 1'b1) begin n_fail++; $display("FAIL single_done0_t2: got %b want 1", write_done_0); end
        n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL single_wen_t2: got %b want 0", reg_write_en); end
        write_en_0 = 1'b0;
        step();
        n_checks++; if (write_done_0 !== 1'b0) begin n_fail++; $display("FAIL single_done0_t3: got %b want 0", write_done_0); end
        n_checks++; if (done0_cnt !== d0 + 1 || done1_cnt !== d1) begin n_fail++; $display("FAIL single_counts: got %0d/%0d want %0d/%0d", done0_cnt, done1_cnt, d0 + 1, d1); end
        n_checks++; if (sr_data !== 32'hA5 || sr_full !== 1'b1) begin n_fail++; $display("FAIL single_reg: got %0h full %b want a5 full 1", sr_data, sr_full); end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        int d1;
        d1 = done1_cnt;
        in_1 = $urandom;
        write_en_1 = 1'b1;
        step();
        n_checks++; if (reg_write_en !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_wen: got %b want 1", reg_write_en); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wen: got %b want 0", reg_write_en); end
        n_checks++; if (write_done_0 !== 1'b0 || write_done_1 !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b%b want 00", write_done_0, write_done_1); end
        n_checks++; if (reg_in !== '0) begin n_fail++; $display("FAIL midrst_reg_in: got %0h want 0", reg_in); end
        write_en_1 = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();
        step();
        n_checks++; if (done1_cnt !== d1) begin n_fail++; $display("FAIL midrst_no_done: got %0d want %0d", done1_cnt, d1); end
    endtask

    task automatic test_simultaneous();
        int base;
        base = wr_log.size();
        in_0 = 32'd1;
        in_1 = 32'd2;
        write_en_0 = 1'b1;
        write_en_1 = 1'b1;
        rd_en = 1'b1;
        step();
        n_checks++; if (reg_in !== 32'd1 || reg_write_en !== 1'b1) begin n_fail++; $display("FAIL sim_grant0: got %0h wen %b want 1 wen 1", reg_in, reg_write_en); end
        step();
        n_checks++; if (write_done_0 !== 1'b1 || write_done_1 !== 1'b0) begin n_fail++; $display("FAIL sim_done0: got %b%b want 10", write_done_0, write_done_1); end
        write_en_0 = 1'b0;
        step();
        n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL sim_idle_t3: got %b want 0", reg_write_en); end
        step();
        n_checks++; if (reg_in !== 32'd2 || reg_write_en !== 1'b1) begin n_fail++; $display("FAIL sim_grant1_t4: got %0h wen %b want 2 wen 1", reg_in, reg_write_en); end
        step();
        n_checks++; if (write_done_1 !== 1'b1 || write_done_0 !== 1'b0) begin n_fail++; $display("FAIL sim_done1_t5: got %b%b want 01", write_done_0, write_done_1); end
        write_en_1 = 1'b0;
        step();
        n_checks++;
        if (wr_log.size() != base + 2) begin
            n_fail++; $display("FAIL sim_log_size: got %0d want %0d", wr_log.size(), base + 2);
        end else if (wr_log[base] !== 32'd1 || wr_log[base+1] !== 32'd2) begin
            n_fail++; $display("FAIL sim_log_order: got %0h,%0h want 1,2", wr_log[base], wr_log[base+1]);
        end
    endtask

    task automatic test_fairness();
        logic [WIDTH-1:0] vals0[4];
        logic [WIDTH-1:0] vals1[4];
        int idx0, idx1, base, dbase, c0, c1, cyc;
        for (int i = 0; i < 4; i++) begin
            vals0[i] = $urandom;
            vals1[i] = $urandom;
        end
        base = wr_log.size();
        dbase = done_log.size();
        c0 = done0_cnt;
        c1 = done1_cnt;
        idx0 = 0;
        idx1 = 0;
        cyc = 0;
        rd_en = 1'b1;
        in_0 = vals0[0];
        in_1 = vals1[0];
        write_en_0 = 1'b1;
        write_en_1 = 1'b1;
        while ((idx0 < 4 || idx1 < 4) && cyc < 200) begin
            step();
            cyc++;
            if (write_done_0 && idx0 < 4) begin
                idx0++;
                if (idx0 < 4) in_0 = vals0[idx0]; else write_en_0 = 1'b0;
            end
            if (write_done_1 && idx1 < 4) begin
                idx1++;
                if (idx1 < 4) in_1 = vals1[idx1]; else write_en_1 = 1'b0;
            end
        end
        write_en_0 = 1'b0;
        write_en_1 = 1'b0;
        step();
        n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL fair_timeout: got %0d/%0d done want 4/4", idx0, idx1); end
        n_checks++; if (done0_cnt - c0 != 4 || done1_cnt - c1 != 4) begin n_fail++; $display("FAIL fair_counts: got %0d/%0d want 4/4", done0_cnt - c0, done1_cnt - c1); end
        n_checks++;
        if (done_log.size() < dbase + 8 || wr_log.size() < base + 8) begin
            n_fail++; $display("FAIL fair_log_size: got %0d dones %0d writes want 8", done_log.size() - dbase, wr_log.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (done_log[dbase+i] != (i % 2)) begin n_fail++; $display("FAIL fair_order_%0d: got writer %0d want %0d", i, done_log[dbase+i], i % 2); end
                n_checks++;
                if (wr_log[base+i] !== ((i % 2 == 0) ? vals0[i/2] : vals1[i/2])) begin
                    n_fail++; $display("FAIL fair_data_%0d: got %0h want %0h", i, wr_log[base+i], (i % 2 == 0) ? vals0[i/2] : vals1[i/2]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int d0, d1;
        bit got;
        rd_en = 1'b1;
        step();
        step();
        rd_en = 1'b0;
        in_1 = 32'h11;
        write_en_1 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (write_done_1) got = 1'b1;
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL bp_prefill: got no done want done"); end
        write_en_1 = 1'b0;
        step();
        n_checks++; if (sr_full !== 1'b1) begin n_fail++; $display("FAIL bp_full: got %b want 1", sr_full); end
        d0 = done0_cnt;
        d1 = done1_cnt;
        in_1 = 32'h3C;
        write_en_1 = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (reg_write_en !== 1'b1 || reg_in !== 32'h3C) begin n_fail++; $display("FAIL bp_hold_%0d: got wen %b data %0h want 1 3c", i, reg_write_en, reg_in); end
            n_checks++; if (write_done_1 !== 1'b0) begin n_fail++; $display("FAIL bp_nodone_%0d: got %b want 0", i, write_done_1); end
            if (i == 4) rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        n_checks++; if (reg_write_en !== 1'b1) begin n_fail++; $display("FAIL bp_land_wen: got %b want 1", reg_write_en); end
        step();
        n_checks++; if (write_done_1 !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", write_done_1); end
        write_en_1 = 1'b0;
        step();
        step();
        n_checks++; if (done1_cnt !== d1 + 1 || done0_cnt !== d0) begin n_fail++; $display("FAIL bp_counts: got %0d/%0d want %0d/%0d", done0_cnt, done1_cnt, d0, d1 + 1); end
        n_checks++; if (sr_data !== 32'h3C) begin n_fail++; $display("FAIL bp_data: got %0h want 3c", sr_data); end
    endtask

    task automatic test_drop_change();
        int d0, base;
        rd_en = 1'b1;
        step();
        step();
        d0 = done0_cnt;
        base = wr_log.size();
        in_0 = 32'd7;
        write_en_0 = 1'b1;
        step();
        n_checks++; if (reg_in !== 32'd7 || reg_write_en !== 1'b1) begin n_fail++; $display("FAIL drop_grant: got %0h wen %b want 7 wen 1", reg_in, reg_write_en); end
        write_en_0 = 1'b0;
        in_0 = 32'd9;
        step();
        n_checks++; if (write_done_0 !== 1'b1) begin n_fail++; $display("FAIL drop_done: got %b want 1", write_done_0); end
        step();
        step();
        step();
        n_checks++; if (done0_cnt !== d0 + 1) begin n_fail++; $display("FAIL drop_count: got %0d want %0d", done0_cnt, d0 + 1); end
        n_checks++;
        if (wr_log.size() != base + 1) begin
            n_fail++; $display("FAIL drop_log_size: got %0d want %0d", wr_log.size(), base + 1);
        end else if (wr_log[base] !== 32'd7) begin
            n_fail++; $display("FAIL drop_data: got %0h want 7", wr_log[base]);
        end
    endtask

    task automatic test_done_in_idle();
        rd_en = 1'b0;
        step();
        inj_done = 1'b1;
        #1;
        n_checks++; if (write_done_0 !== 1'b0 || write_done_1 !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %b%b want 00", write_done_0, write_done_1); end
        n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL idle_wen: got %b want 0", reg_write_en); end
        n_checks++; if (reg_in !== 32'd7) begin n_fail++; $display("FAIL idle_hold: got %0h want 7", reg_in); end
        step();
        inj_done = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] data0, data1;
        bit req0, req1;
        int issued0, issued1, comp0, comp1;
        req0 = 1'b0;
        req1 = 1'b0;
        issued0 = 0;
        issued1 = 0;
        comp0 = 0;
        comp1 = 0;
        data0 = '0;
        data1 = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            if (write_done_0 && write_done_1) begin
                n_checks++; n_fail++; $display("FAIL rand_both_done: got 11 want at most one");
            end
            if (write_done_0) begin
                n_checks++; if (!req0) begin n_fail++; $display("FAIL rand_done0_unreq: got done want none"); end
                n_checks++;
                if (wr_log.size() == 0 || wr_log[wr_log.size()-1] !== data0) begin
                    n_fail++; $display("FAIL rand_data0: got %0h want %0h", (wr_log.size() == 0) ? '0 : wr_log[wr_log.size()-1], data0);
                end
                req0 = 1'b0;
                write_en_0 = 1'b0;
                comp0++;
            end
            if (write_done_1) begin
                n_checks++; if (!req1) begin n_fail++; $display("FAIL rand_done1_unreq: got done want none"); end
                n_checks++;
                if (wr_log.size() == 0 || wr_log[wr_log.size()-1] !== data1) begin
                    n_fail++; $display("FAIL rand_data1: got %0h want %0h", (wr_log.size() == 0) ? '0 : wr_log[wr_log.size()-1], data1);
                end
                req1 = 1'b0;
                write_en_1 = 1'b0;
                comp1++;
            end
            if (cyc < 300) begin
                if (!req0 && ($urandom % 4) == 0) begin
                    data0 = $urandom; in_0 = data0; req0 = 1'b1; write_en_0 = 1'b1; issued0++;
                end
                if (!req1 && ($urandom % 4) == 0) begin
                    data1 = $urandom; in_1 = data1; req1 = 1'b1; write_en_1 = 1'b1; issued1++;
                end
                rd_en = 1'($urandom % 2);
            end else begin
                rd_en = 1'b1;
            end
        end
        n_checks++; if (comp0 != issued0) begin n_fail++; $display("FAIL rand_complete0: got %0d want %0d", comp0, issued0); end
        n_checks++; if (comp1 != issued1) begin n_fail++; $display("FAIL rand_complete1: got %0d want %0d", comp1, issued1); end
    endtask

    initial begin
        in_0 = '0;
        in_1 = '0;
        test_reset();
        test_single_write();
        test_reset_mid_busy();
        test_simultaneous();
        test_fairness();
        test_back_pressure();
        test_drop_change();
        test_done_in_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/std_sync_write_arbiter.md
Name: std_sync_write_arbiter

Overview:
- Two-writer round-robin arbiter placed directly upstream of the M-structure sync register (std_sync_reg).
- Serialises write requests from two parallel threads onto the register's single in/write_en port.
- Routes the register's done pulse back to the writer that was granted.
- Latches the granted writer's data, so a writer only needs to hold its request, not a stable value, after the grant.

Parameters:
- WIDTH, 32, data width; must match the downstream sync register's WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_0  input  WIDTH  write data from writer 0.
- write_en_0  input  1  writer 0 request; held high until write_done_0.
- in_1  input  WIDTH  write data from writer 1.
- write_en_1  input  1  writer 1 request; held high until write_done_1.
- reg_done  input  1  done output of the downstream sync register.
- reg_in  output  WIDTH  data to the sync register's in port.
- reg_write_en  output  1  to the sync register's write_en port.
- write_done_0  output  1  one-cycle completion pulse for writer 0.
- write_done_1  output  1  one-cycle completion pulse for writer 1.

Behaviour:
- Reset:
  - Async assertion forces state IDLE, data latch 0 and last_grant 1, so writer 0 wins the first tie.
  - Outputs reg_in=0, reg_write_en=0, write_done_0/1=0 are effective immediately, without a clock.
  - Reset mid-transaction abandons the transaction; no done pulse is produced.
- States: IDLE, BUSY_0, BUSY_1.
- IDLE:
  - Only one request high: go to BUSY_k for that writer and latch in_k into the data register on the same edge.
  - Both requests high: grant the writer that is not last_grant.
  - Neither request high: stay in IDLE.
- BUSY_k:
  - reg_in = latched data.
  - reg_write_en = !reg_done, which prevents a spurious second write/blocked on the done cycle.
  - Stay in BUSY_k while the sync register is full; reg_write_en remains high (back-pressure).
- Completion: when reg_done=1 in BUSY_k:
  - write_done_k = 1 combinationally in the same cycle.
  - Next state is IDLE and last_grant is set to k.
  - write_done of the other writer is never asserted.
- Latency with the sync register empty:
  - Request at cycle t in IDLE → BUSY at t+1 with reg_write_en=1.
  - Register accepts at the end of t+1 → reg_done and write_done_k at t+2 → IDLE at t+3.
  - The next grant is possible from t+3.
- Request handling:
  - Dropping write_en_k during BUSY_k is ignored; the latched write still completes and done still pulses.
  - Changing in_k after the grant has no effect.
- reg_done seen in IDLE is ignored and must not produce any write_done.
- reg_in holds its last latched value in IDLE; reg_write_en=0 in IDLE.
- No combinational path from write_en_* to reg_write_en; grant always takes one cycle.

Test Plan:
- Reset mid-BUSY_1, asserted asynchronously between edges → reg_write_en, write_done_0/1 go 0 immediately. After release, simultaneous requests → grant to writer 0.
- Single write: write_en_0=1, in_0=0xA5 at t with the register empty → reg_write_en=1 and reg_in=0xA5 at t+1; write_done_0=1 at t+2 only; write_done_1 stays 0; register holds 0xA5.
- Simultaneous requests after reset, in_0=1, in_1=2, both held → writer 0 is served first (done at t+2), then writer 1 (grant at t+4, done at t+5). The register receives 1 then 2, with a reader draining between writes.
- Fairness: both writers re-request continuously for 8 transactions → grants alternate 0,1,0,1,…; each writer receives exactly 4 write_done pulses.
- Back-pressure: register pre-filled (no reader) and writer 1 requests 0x3C → BUSY_1 with reg_write_en=1 held for 5 cycles, no done. The reader reads, then the write lands and write_done_1 pulses once.
- Request drop/data change: writer 0 granted with in_0=7, then write_en_0 drops and in_0 changes to 9 → the register still receives 7 and write_done_0 pulses once.
